// File: rtl/csa_bist_vector_gen.sv
// BIST sequencer for the CSA 3x3 multiplier array: sweeps all 64 operand pairs and strobes the fault selector.
// Define CSA_BIST_LFSR_EN to source vectors from a 6-bit LFSR instead of a binary counter.
module csa_bist_vector_gen #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned PASSES = 1
) (
  input  logic       clk,
  input  logic       init,
  input  logic       start,
  output logic [2:0] op_a,
  output logic [2:0] op_b,
  output logic [5:0] desired_output,
  output logic       sel_init,
  output logic       sel_test,
  output logic [5:0] vec_idx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned VEC_W  = 6;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PASS_W = 3;
  localparam logic [VEC_W-1:0] LAST_VEC = 6'd63;

  typedef enum logic [2:0] {IDLE, CLR, APPLY, STROBE, DONE} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    settle_cnt, settle_d;
  logic [PASS_W-1:0]   pass_cnt, pass_d;
  logic [VEC_W-1:0]    vec_d, pair_d;
  logic [2:0]          op_a_d, op_b_d;
  logic [5:0]          desired_d;
  logic                sel_init_d, sel_test_d, busy_d, done_d;

`ifdef CSA_BIST_LFSR_EN
  localparam logic [VEC_W-1:0] SEED = 6'b000001;
  logic [VEC_W-1:0]    lfsr, lfsr_d;
`endif

  // Next-state, counters and next values of all registered outputs
  always_comb begin
    state_d  = state;
    vec_d    = vec_idx;
    pass_d   = pass_cnt;
    settle_d = settle_cnt;
`ifdef CSA_BIST_LFSR_EN
    lfsr_d   = lfsr;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d  = CLR;
          vec_d    = '0;
          pass_d   = '0;
          settle_d = CNT_W'(SETTLE);
`ifdef CSA_BIST_LFSR_EN
          lfsr_d   = SEED;
`endif
        end
      end
      CLR: state_d = APPLY;
      APPLY: begin
        if (settle_cnt == CNT_W'(1)) state_d = STROBE;
        else settle_d = settle_cnt - CNT_W'(1);
      end
      STROBE: begin
        settle_d = CNT_W'(SETTLE);
        if (vec_idx != LAST_VEC) begin
          state_d = APPLY;
          vec_d   = vec_idx + 6'd1;
`ifdef CSA_BIST_LFSR_EN
          lfsr_d  = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
`endif
        end else if (pass_cnt != PASS_W'(PASSES - 1)) begin
          // new pass without a selector clear so faults keep accumulating
          state_d = APPLY;
          pass_d  = pass_cnt + PASS_W'(1);
          vec_d   = '0;
`ifdef CSA_BIST_LFSR_EN
          lfsr_d  = SEED;
`endif
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef CSA_BIST_LFSR_EN
    pair_d = (vec_d == LAST_VEC) ? '0 : lfsr_d;
`else
    pair_d = vec_d;
`endif

    op_a_d = '0;
    op_b_d = '0;
    if (state_d == APPLY || state_d == STROBE) begin
      op_a_d = pair_d[5:3];
      op_b_d = pair_d[2:0];
    end
    desired_d  = 6'(op_a_d) * 6'(op_b_d);
    sel_init_d = (state_d == CLR);
    sel_test_d = (state_d == STROBE);
    busy_d     = (state_d == CLR) || (state_d == APPLY) || (state_d == STROBE);
    done_d     = (state_d == DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      pass_cnt       <= '0;
      vec_idx        <= '0;
      op_a           <= '0;
      op_b           <= '0;
      desired_output <= '0;
      sel_init       <= 1'b0;
      sel_test       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef CSA_BIST_LFSR_EN
      lfsr           <= '0;
`endif
    end else begin
      state          <= state_d;
      settle_cnt     <= settle_d;
      pass_cnt       <= pass_d;
      vec_idx        <= vec_d;
      op_a           <= op_a_d;
      op_b           <= op_b_d;
      desired_output <= desired_d;
      sel_init       <= sel_init_d;
      sel_test       <= sel_test_d;
      busy           <= busy_d;
      done           <= done_d;
`ifdef CSA_BIST_LFSR_EN
      lfsr           <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_csa_bist_vector_gen.sv
// Self-checking bench for csa_bist_vector_gen: two parameterisations checked cycle by cycle against a timing model.
module tb_csa_bist_vector_gen;

  logic clk = 1'b0;
  logic init = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;

  logic [2:0] a0, b0, a1, b1;
  logic [5:0] d0, d1, v0, v1;
  logic si0, st0, bz0, dn0, si1, st1, bz1, dn1;

  logic [21:0] obs0, obs1;
  assign obs0 = {a0, b0, d0, si0, st0, v0, bz0, dn0};
  assign obs1 = {a1, b1, d1, si1, st1, v1, bz1, dn1};

  always #5 clk = ~clk;

  csa_bist_vector_gen u_dut0 (
    .clk(clk), .init(init), .start(start0),
    .op_a(a0), .op_b(b0), .desired_output(d0),
    .sel_init(si0), .sel_test(st0), .vec_idx(v0), .busy(bz0), .done(dn0)
  );

  csa_bist_vector_gen #(.SETTLE(3), .PASSES(2)) u_dut1 (
    .clk(clk), .init(init), .start(start1),
    .op_a(a1), .op_b(b1), .desired_output(d1),
    .sel_init(si1), .sel_test(st1), .vec_idx(v1), .busy(bz1), .done(dn1)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [5:0] tbl [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected outputs t cycles after the start edge: CLR, then 64*PASSES vectors of SETTLE+1 cycles, then DONE
  function automatic logic [21:0] model(input int t, input int s, input int p);
    logic [21:0] r;
    logic [5:0]  pr;
    int u, k, ph;
    r = '0;
    if (t == 0) begin
      r[9] = 1'b1;
      r[1] = 1'b1;
    end else begin
      u = t - 1;
      if (u < 64 * (s + 1) * p) begin
        k  = (u / (s + 1)) % 64;
        ph = u % (s + 1);
        pr = tbl[k];
        r[21:16] = pr;
        r[15:10] = 6'(int'(pr[5:3]) * int'(pr[2:0]));
        r[8]     = (ph == s);
        r[7:2]   = 6'(k);
        r[1]     = 1'b1;
      end else begin
        r[7:2] = 6'd63;
        r[0]   = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [21:0] observe(input int which);
    return (which == 1) ? obs1 : obs0;
  endfunction

  task automatic drive_start(input int which, input logic val);
    if (which == 1) start1 = val;
    else start0 = val;
  endtask

  // One complete run from IDLE or DONE, optionally with random start pulses while busy
  task automatic run(input int which, input int s, input int p, input bit noise);
    int total;
    int n_test, n_init;
    bit [63:0] seen;
    logic [21:0] o;
    total  = 64 * (s + 1) * p;
    n_test = 0;
    n_init = 0;
    seen   = '0;
    @(negedge clk);
    drive_start(which, 1'b1);
    for (int t = 0; t <= total + 2; t++) begin
      @(negedge clk);
      o = observe(which);
      check($sformatf("dut%0d t=%0d", which, t), 32'(o), 32'(model(t, s, p)));
      if (o[9]) n_init++;
      if (o[8]) begin
        n_test++;
        seen[o[21:16]] = 1'b1;
        if (o[15:10] !== 6'(int'(o[21:19]) * int'(o[18:16])))
          check($sformatf("dut%0d product t=%0d", which, t), 32'(o[15:10]),
                32'(int'(o[21:19]) * int'(o[18:16])));
      end
      if (noise && t <= total && $urandom_range(7) == 0) drive_start(which, 1'b1);
      else drive_start(which, 1'b0);
    end
    check($sformatf("dut%0d strobes", which), 32'(n_test), 32'(64 * p));
    check($sformatf("dut%0d inits", which), 32'(n_init), 32'd1);
    check($sformatf("dut%0d pair cover", which), 32'(seen == '1), 32'd1);
  endtask

  initial begin
    logic [5:0] s;
    logic [21:0] o;
    int quiet;
`ifdef CSA_BIST_LFSR_EN
    s = 6'b000001;
    for (int k = 0; k < 63; k++) begin
      tbl[k] = s;
      s = {s[4:0], s[5] ^ s[4]};
    end
    tbl[63] = '0;
`else
    s = '0;
    for (int k = 0; k < 64; k++) tbl[k] = 6'(k);
`endif

    #1;
    check("reset dut0", 32'(obs0), 32'd0);
    check("reset dut1", 32'(obs1), 32'd0);
    @(negedge clk);
    init = 1'b0;
    repeat ($urandom_range(5, 1)) @(negedge clk);
    check("idle dut0", 32'(obs0), 32'd0);

    run(0, 1, 1, 1'b0);
    repeat ($urandom_range(4)) @(negedge clk);
    check("done hold dut0", 32'(obs0), 32'(model(200, 1, 1)));
    run(0, 1, 1, 1'b1);

    // async reset while vector 20 is applied
    @(negedge clk);
    start0 = 1'b1;
    for (int t = 0; t <= 41; t++) begin
      @(negedge clk);
      start0 = 1'b0;
      check($sformatf("pre-rst t=%0d", t), 32'(obs0), 32'(model(t, 1, 1)));
    end
    check("pre-rst vec", 32'(v0), 32'd20);
    init = 1'b1;
    #1;
    check("rst async", 32'(obs0), 32'd0);
    @(negedge clk);
    init = 1'b0;
    quiet = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      o = obs0;
      if (o != '0) quiet++;
    end
    check("post-rst quiet", 32'(quiet), 32'd0);

    run(1, 3, 2, 1'b1);
    repeat ($urandom_range(3)) @(negedge clk);
    run(1, 3, 2, 1'b0);
    run(0, 1, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
